shiftreg_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one fixed-latency byte shift pipeline between two requesters (A and B). Each cycle it grants at most one requester and loads that requester's byte into stage 0. It tags every stage with a valid bit and a source ID, and drains the pipeline on command. It sits in front of the multi-stage shift-register datapath. Downstream logic gets `dout`, `dout_valid` and `dout_src` exactly DEPTH cycles after the grant.

---
 rtl/shiftreg_rr_arbiter_if.sv | 30 +++
 rtl/shiftreg_rr_arbiter.sv | 98 +++++++++
 tb/tb_shiftreg_rr_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/shiftreg_rr_arbiter_if.sv
// Handshake and result bundle between the two requesters and the shared shift pipeline.
interface shiftreg_rr_arbiter_if #(
  parameter int W     = 8,
  parameter int DEPTH = 3
);
  localparam int OW = $clog2(DEPTH + 1);

  logic          req_a;
  logic [W-1:0]  din_a;
  logic          gnt_a;
  logic          req_b;
  logic [W-1:0]  din_b;
  logic          gnt_b;
  logic          flush;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_src;
  logic [OW-1:0] occ;
  logic          busy;

  modport master (
    output req_a, din_a, req_b, din_b, flush,
    input  gnt_a, gnt_b, dout, dout_valid, dout_src, occ, busy
  );

  modport slave (
    input  req_a, din_a, req_b, din_b, flush,
    output gnt_a, gnt_b, dout, dout_valid, dout_src, occ, busy
  );
endinterface

// File: rtl/shiftreg_rr_arbiter.sv
// Round-robin arbiter feeding a fixed-latency, never-stalling byte shift pipeline.
// Each stage carries {data, valid, src}; output is DEPTH cycles after the grant.
module shiftreg_rr_arbiter #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input logic                  ck,
  input logic                  reset,
  shiftreg_rr_arbiter_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state;
  logic                    busy;
  logic                    prio;
  logic [OW-1:0]           occ;
  logic [OW-1:0]           occ_next;
  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0]        src_pipe;
  logic [DEPTH-1:0][W-1:0] data_pipe;

  logic                    block;
  logic                    gnt_a;
  logic                    gnt_b;
  logic                    grant;
  logic [W-1:0]            gnt_data;

  // Grants depend only on requests, flush, prio and state -- never on data.
  always_comb begin
    block    = (state == FLUSH) | bus.flush;
    gnt_a    = bus.req_a & ~block & (~bus.req_b | ~prio);
    gnt_b    = bus.req_b & ~block & (~bus.req_a |  prio);
    grant    = gnt_a | gnt_b;
    gnt_data = gnt_a ? bus.din_a : (gnt_b ? bus.din_b : '0);
    occ_next = occ + OW'(grant) - OW'(vld_pipe[DEPTH-1]);
  end

  // Bubbles enter as all-zero so dout/src read 0 whenever the stage is invalid.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      src_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[DEPTH-2:0], grant};
      src_pipe  <= {src_pipe[DEPTH-2:0], gnt_b};
      data_pipe <= {data_pipe[DEPTH-2:0], gnt_data};
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      prio  <= 1'b0;
      occ   <= '0;
    end else begin
      occ <= occ_next;
      if (grant) prio <= gnt_a;
      case (state)
        IDLE: begin
          if (grant) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (occ_next == '0 && !grant) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bus.flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (occ_next == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_a      = gnt_a;
  assign bus.gnt_b      = gnt_b;
  assign bus.dout       = data_pipe[DEPTH-1];
  assign bus.dout_valid = vld_pipe[DEPTH-1];
  assign bus.dout_src   = src_pipe[DEPTH-1];
  assign bus.occ        = occ;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_shiftreg_rr_arbiter.sv
// Directed table of per-cycle vectors plus a hand-written mid-stream reset sequence.
module tb_shiftreg_rr_arbiter;
  logic ck;
  logic reset;
  int   tests;
  int   fails;

  shiftreg_rr_arbiter_if #(.W(8), .DEPTH(3)) bus ();

  shiftreg_rr_arbiter #(.W(8), .DEPTH(3)) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic       ra;
    logic [7:0] da;
    logic       rb;
    logic [7:0] db;
    logic       fl;
    logic       ga;
    logic       gb;
    logic       dv;
    logic [7:0] dout;
    logic       src;
    logic [1:0] occ;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic ra, input logic [7:0] da, input logic rb,
                              input logic [7:0] db, input logic fl, input logic ga,
                              input logic gb, input logic dv, input logic [7:0] dout,
                              input logic src, input logic [1:0] occ, input logic busy);
    vec_t v;
    v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.fl = fl;
    v.ga = ga; v.gb = gb; v.dv = dv; v.dout = dout; v.src = src;
    v.occ = occ; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ra, input logic [7:0] da, input logic rb,
                       input logic [7:0] db, input logic fl);
    bus.req_a = ra; bus.din_a = da;
    bus.req_b = rb; bus.din_b = db;
    bus.flush = fl;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);

    // Contention: A first, then alternate.
    vq.push_back(mk(1,8'hA0,1,8'hB0,0, 1,0,0,8'h00,0,0,0));
    vq.push_back(mk(1,8'hA1,1,8'hB1,0, 0,1,0,8'h00,0,1,1));
    vq.push_back(mk(1,8'hA2,1,8'hB2,0, 1,0,0,8'h00,0,2,1));
    vq.push_back(mk(1,8'hA3,1,8'hB3,0, 0,1,1,8'hA0,0,3,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'hB1,1,3,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'hA2,0,2,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'hB3,1,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,0,0));
    // Single A byte.
    vq.push_back(mk(1,8'h5A,0,8'h00,0, 1,0,0,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'h5A,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,0,0));
    // Full pipeline: six B bytes back to back.
    vq.push_back(mk(0,8'h00,1,8'h10,0, 0,1,0,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,1,8'h11,0, 0,1,0,8'h00,0,1,1));
    vq.push_back(mk(0,8'h00,1,8'h12,0, 0,1,0,8'h00,0,2,1));
    vq.push_back(mk(0,8'h00,1,8'h13,0, 0,1,1,8'h10,1,3,1));
    vq.push_back(mk(0,8'h00,1,8'h14,0, 0,1,1,8'h11,1,3,1));
    vq.push_back(mk(0,8'h00,1,8'h15,0, 0,1,1,8'h12,1,3,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'h13,1,3,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'h14,1,2,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'h15,1,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,0,0));
    // Flush with two in flight; A kept requesting through the drain.
    vq.push_back(mk(1,8'h21,0,8'h00,0, 1,0,0,8'h00,0,0,0));
    vq.push_back(mk(1,8'h22,0,8'h00,0, 1,0,0,8'h00,0,1,1));
    vq.push_back(mk(1,8'h23,0,8'h00,1, 0,0,0,8'h00,0,2,1));
    vq.push_back(mk(1,8'h24,0,8'h00,0, 0,0,1,8'h21,0,2,1));
    vq.push_back(mk(1,8'h25,0,8'h00,0, 0,0,1,8'h22,0,1,1));
    vq.push_back(mk(1,8'h26,0,8'h00,0, 1,0,0,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'h26,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,0,0));
    // Flush while idle: prio (now favouring B) must survive.
    vq.push_back(mk(1,8'h30,1,8'h40,1, 0,0,0,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,0,0));
    vq.push_back(mk(1,8'h31,1,8'h41,0, 0,1,0,8'h00,0,0,0));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,1,8'h41,1,1,1));
    vq.push_back(mk(0,8'h00,0,8'h00,0, 0,0,0,8'h00,0,0,0));

    // Reset state
    @(posedge ck); #1;
    @(posedge ck); #3;
    chk("reset dout_valid", 32'(bus.dout_valid), 32'h0);
    chk("reset dout", 32'(bus.dout), 32'h0);
    chk("reset occ", 32'(bus.occ), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset gnt_a idle", 32'(bus.gnt_a), 32'h0);
    @(posedge ck); #1;
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge ck); #1;
      drive(vq[i].ra, vq[i].da, vq[i].rb, vq[i].db, vq[i].fl);
      #3;
      chk($sformatf("row%0d gnt_a", i), 32'(bus.gnt_a), 32'(vq[i].ga));
      chk($sformatf("row%0d gnt_b", i), 32'(bus.gnt_b), 32'(vq[i].gb));
      chk($sformatf("row%0d dout_valid", i), 32'(bus.dout_valid), 32'(vq[i].dv));
      chk($sformatf("row%0d dout", i), 32'(bus.dout), 32'(vq[i].dout));
      chk($sformatf("row%0d dout_src", i), 32'(bus.dout_src), 32'(vq[i].src));
      chk($sformatf("row%0d occ", i), 32'(bus.occ), 32'(vq[i].occ));
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(vq[i].busy));
    end

    // Mid-stream reset with three bytes in flight.
    @(posedge ck); #1; drive(1, 8'h51, 0, 8'h00, 0);
    @(posedge ck); #1; drive(1, 8'h52, 0, 8'h00, 0);
    @(posedge ck); #1; drive(1, 8'h53, 0, 8'h00, 0);
    @(posedge ck); #1; drive(0, 8'h00, 0, 8'h00, 0);
    #1;
    chk("pre-reset occ", 32'(bus.occ), 32'h3);
    chk("pre-reset dout_valid", 32'(bus.dout_valid), 32'h1);
    chk("pre-reset dout", 32'(bus.dout), 32'h51);
    reset = 1'b1;
    #1;
    chk("async reset dout_valid", 32'(bus.dout_valid), 32'h0);
    chk("async reset dout", 32'(bus.dout), 32'h0);
    chk("async reset dout_src", 32'(bus.dout_src), 32'h0);
    chk("async reset occ", 32'(bus.occ), 32'h0);
    chk("async reset busy", 32'(bus.busy), 32'h0);
    bus.req_a = 1'b1;
    #1;
    chk("gnt_a during reset", 32'(bus.gnt_a), 32'h1);
    bus.req_a = 1'b0;
    @(posedge ck); #1;
    @(posedge ck); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge ck); #3;
      chk($sformatf("post-reset c%0d dout_valid", i), 32'(bus.dout_valid), 32'h0);
      chk($sformatf("post-reset c%0d dout", i), 32'(bus.dout), 32'h0);
      chk($sformatf("post-reset c%0d busy", i), 32'(bus.busy), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
